// File: rtl/ula_pkg.sv
// ula_pkg: opcodes, controller states and opcode helpers shared by the ULA sequencing logic.
package ula_pkg;
  localparam logic [2:0] OP_NOTUSE = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_SUB    = 3'b010;
  localparam logic [2:0] OP_MUL    = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_AND    = 3'b101;
  localparam logic [2:0] OP_OR     = 3'b110;
  localparam logic [2:0] OP_XOR    = 3'b111;
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, CAPTURE, DONE} state_t;
  function automatic logic is_multicycle(input logic [2:0] op);
    return op == OP_MUL || op == OP_DIV;
  endfunction
endpackage

// File: rtl/ula_timeout_counter.sv
// ula_timeout_counter: counts WAIT cycles; Expired marks the last cycle allowed before abort.
module ula_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clear,
  input  logic Enable,
  output logic Expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign Expired = cnt_q == W'(TIMEOUT_CYCLES - 1);
  always_comb cnt_d = Clear ? '0 : (Enable && !Expired) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/ula_op_controller.sv
// ula_op_controller: sequences one ULA operation at a time (load, issue, wait, capture, done).
// Define ULA_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT_CYCLES with Error set.
module ula_op_controller
  import ula_pkg::*;
#(
  parameter int SEL_W          = 3,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [SEL_W-1:0] OpCode,
  input  logic             DivisorZero,
  input  logic             MulReady,
  input  logic             DivReady,
  output logic [SEL_W-1:0] Selector,
  output logic             LoadOperands,
  output logic             StartMul,
  output logic             StartDiv,
  output logic             LoadResult,
  output logic             Busy,
  output logic             Done,
  output logic             Error
);
  state_t state_q, state_d;
  logic [SEL_W-1:0] op_q, op_d;
  logic err_q, err_d;
  logic ready, expired;
  assign ready = (op_q == OP_MUL) ? MulReady : DivReady;
`ifdef ULA_TIMEOUT_EN
  ula_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .Clock   (Clock),
    .Reset   (Reset),
    .Clear   (state_q != WAIT),
    .Enable  (state_q == WAIT),
    .Expired (expired)
  );
`else
  assign expired = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (Start) begin
        state_d = LOAD;
        op_d    = OpCode;
        err_d   = 1'b0;
      end
      LOAD: if (op_q == OP_NOTUSE || (op_q == OP_DIV && DivisorZero)) begin
        state_d = DONE;
        err_d   = 1'b1;
      end else state_d = is_multicycle(op_q) ? ISSUE : CAPTURE;
      ISSUE: state_d = WAIT;
      // Ready beats an expiring timer in the same cycle
      WAIT: if (ready) state_d = CAPTURE;
      else if (expired) begin
        state_d = DONE;
        err_d   = 1'b1;
      end
      CAPTURE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  assign Selector     = (state_q == IDLE) ? '0 : op_q;
  assign LoadOperands = state_q == LOAD;
  assign StartMul     = state_q == ISSUE && op_q == OP_MUL;
  assign StartDiv     = state_q == ISSUE && op_q == OP_DIV;
  assign LoadResult   = state_q == CAPTURE;
  assign Busy         = state_q != IDLE;
  assign Done         = state_q == DONE;
  assign Error        = err_q;
endmodule

// File: tb/tb_ula_op_controller.sv
// tb_ula_op_controller: directed self-checking bench for ula_op_controller.
module tb_ula_op_controller;
  logic Clock = 1'b0, Reset = 1'b0, Start = 1'b0;
  logic DivisorZero = 1'b0, MulReady = 1'b0, DivReady = 1'b0;
  logic [2:0] OpCode = 3'd0;
  logic [2:0] Selector;
  logic LoadOperands, StartMul, StartDiv, LoadResult, Busy, Done, Error;
  int errors = 0, checks = 0;
  // {Selector, LoadOperands, StartMul, StartDiv, LoadResult, Busy, Done, Error}
  wire [9:0] obs = {Selector, LoadOperands, StartMul, StartDiv, LoadResult, Busy, Done, Error};

  ula_op_controller dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .OpCode(OpCode),
    .DivisorZero(DivisorZero), .MulReady(MulReady), .DivReady(DivReady),
    .Selector(Selector), .LoadOperands(LoadOperands), .StartMul(StartMul),
    .StartDiv(StartDiv), .LoadResult(LoadResult), .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] op);
    Start = 1'b1;
    OpCode = op;
    tick();
    Start = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    #1;
    checks++;
    if (obs !== 10'b0) begin errors++; $display("FAIL reset_init: got %b expected %b", obs, 10'b0); end
    tick();
    Reset = 1'b0;
    tick();
    issue(3'd3);
    tick();
    tick();
    checks++;
    if (obs !== {3'd3, 7'b0000100}) begin errors++; $display("FAIL reset_prewait: got %b expected %b", obs, {3'd3, 7'b0000100}); end
    Reset = 1'b1;
    #1;
    checks++;
    if (obs !== 10'b0) begin errors++; $display("FAIL reset_midwait: got %b expected %b", obs, 10'b0); end
    #1;
    Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (obs !== 10'b0) begin errors++; $display("FAIL reset_after c%0d: got %b expected %b", c, obs, 10'b0); end
    end
  endtask

  task automatic test_single(input logic [2:0] op);
    logic [9:0] exp [4];
    exp = '{{op, 7'b1000100}, {op, 7'b0001100}, {op, 7'b0000110}, 10'b0};
    issue(op);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obs !== exp[c]) begin errors++; $display("FAIL single op%0d cyc%0d: got %b expected %b", op, c + 1, obs, exp[c]); end
      tick();
    end
  endtask

  task automatic test_mul;
    logic [9:0] exp [3];
    issue(3'd3);
    checks++;
    if (obs !== {3'd3, 7'b1000100}) begin errors++; $display("FAIL mul_load: got %b expected %b", obs, {3'd3, 7'b1000100}); end
    MulReady = 1'b1;
    DivReady = 1'b1;
    tick();
    checks++;
    if (obs !== {3'd3, 7'b0100100}) begin errors++; $display("FAIL mul_issue: got %b expected %b", obs, {3'd3, 7'b0100100}); end
    tick();
    MulReady = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (obs !== {3'd3, 7'b0000100}) begin errors++; $display("FAIL mul_wait w%0d: got %b expected %b", c, obs, {3'd3, 7'b0000100}); end
      if (c == 4) MulReady = 1'b1;
      tick();
    end
    MulReady = 1'b0;
    DivReady = 1'b0;
    exp = '{{3'd3, 7'b0001100}, {3'd3, 7'b0000110}, 10'b0};
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs !== exp[c]) begin errors++; $display("FAIL mul_tail cyc%0d: got %b expected %b", c + 8, obs, exp[c]); end
      tick();
    end
  endtask

  task automatic test_error(input logic [2:0] op);
    logic [9:0] exp [4];
    exp = '{{op, 7'b1000100}, {op, 7'b0000111}, 10'b0000000001, 10'b0000000001};
    DivisorZero = 1'b1;
    issue(op);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obs !== exp[c]) begin errors++; $display("FAIL error op%0d cyc%0d: got %b expected %b", op, c + 1, obs, exp[c]); end
      tick();
    end
    DivisorZero = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp [6];
    Start = 1'b1;
    OpCode = 3'd4;
    tick();
    OpCode = 3'd1;
    checks++;
    if (obs !== {3'd4, 7'b1000100}) begin errors++; $display("FAIL b2b_load: got %b expected %b", obs, {3'd4, 7'b1000100}); end
    tick();
    checks++;
    if (obs !== {3'd4, 7'b0010100}) begin errors++; $display("FAIL b2b_issue: got %b expected %b", obs, {3'd4, 7'b0010100}); end
    tick();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (obs !== {3'd4, 7'b0000100}) begin errors++; $display("FAIL b2b_wait w%0d: got %b expected %b", c, obs, {3'd4, 7'b0000100}); end
      if (c == 9) DivReady = 1'b1;
      tick();
    end
    DivReady = 1'b0;
    exp = '{{3'd4, 7'b0001100}, {3'd4, 7'b0000110}, 10'b0, {3'd1, 7'b1000100}, {3'd1, 7'b0001100}, {3'd1, 7'b0000110}};
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (obs !== exp[c]) begin errors++; $display("FAIL b2b_tail cyc%0d: got %b expected %b", c + 13, obs, exp[c]); end
      if (c == 3) Start = 1'b0;
      tick();
    end
    checks++;
    if (obs !== 10'b0) begin errors++; $display("FAIL b2b_idle: got %b expected %b", obs, 10'b0); end
  endtask

  task automatic test_timeout;
    issue(3'd3);
    tick();
    tick();
`ifdef ULA_TIMEOUT_EN
    for (int c = 0; c < 32; c++) begin
      checks++;
      if (obs !== {3'd3, 7'b0000100}) begin errors++; $display("FAIL tmo_wait w%0d: got %b expected %b", c, obs, {3'd3, 7'b0000100}); end
      tick();
    end
    checks++;
    if (obs !== {3'd3, 7'b0000111}) begin errors++; $display("FAIL tmo_done: got %b expected %b", obs, {3'd3, 7'b0000111}); end
    tick();
    checks++;
    if (obs !== 10'b0000000001) begin errors++; $display("FAIL tmo_idle: got %b expected %b", obs, 10'b0000000001); end
`else
    begin
      logic seen_lr, seen_done;
      seen_lr = 1'b0;
      seen_done = 1'b0;
      for (int c = 0; c < 101; c++) begin
        seen_lr |= LoadResult;
        seen_done |= Done;
        tick();
      end
      checks++;
      if ({seen_lr, seen_done, obs} !== {2'b00, 3'd3, 7'b0000100})
        begin errors++; $display("FAIL hold_wait: got lr=%b done=%b %b expected lr=0 done=0 %b", seen_lr, seen_done, obs, {3'd3, 7'b0000100}); end
      Reset = 1'b1;
      #1;
      Reset = 1'b0;
      checks++;
      if (obs !== 10'b0) begin errors++; $display("FAIL hold_reset: got %b expected %b", obs, 10'b0); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single(3'd1);
    test_single(3'd2);
    test_single(3'd5);
    test_single(3'd6);
    test_single(3'd7);
    test_mul();
    test_error(3'd4);
    test_error(3'd0);
    test_single(3'd1);
    test_back_to_back();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
